usb_tx_encoder: RTL
===================

Name: usb_tx_encoder

Overview:
- USB full-speed transmit encoder directly downstream of the endpoint data buffer.
- On command from the protocol controller it serializes one packet onto the D+/D- lines: SYNC, PID, optional payload and CRC16, then EOP.
- Payload bytes are pulled one at a time from the data buffer through its get_tx_packet_data / tx_packet_data interface.
- Bit stuffing and NRZI are applied on the fly.

Parameters:
- CLKS_PER_BIT, 4, system clocks per USB bit time (48 MHz clk, 12 Mbps line).
- MAX_PAYLOAD, 64, maximum data bytes per packet; equals the data buffer depth.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- tx_start  input  1  one-cycle pulse from protocol controller: begin packet
- tx_packet  input  3  packet type: 1=DATA0, 2=DATA1, 3=ACK, 4=NAK, 5=STALL, others invalid
- buffer_occupancy  input  7  bytes currently held in the data buffer
- tx_packet_data  input  8  byte returned by the data buffer, valid the cycle after a request
- get_tx_packet_data  output  1  one-cycle request for the next payload byte
- dplus_out  output  1  D+ line drive
- dminus_out  output  1  D- line drive
- tx_transfer_active  output  1  high from accepted tx_start through the last EOP J bit
- tx_done  output  1  one-cycle pulse when the packet completes
- tx_error  output  1  one-cycle pulse when tx_start carries an invalid tx_packet code

Behaviour:
- Reset values: dplus_out=1, dminus_out=0 (idle J), all other outputs 0, FSM in IDLE.
- Reset mid-packet aborts at once; lines return to J asynchronously; no tx_done is issued.
- FSM states: IDLE -> SYNC -> PID -> (DATA -> CRC_LO -> CRC_HI, for DATA0/1 only) -> EOP_SE0 -> EOP_J -> IDLE.
- tx_start in IDLE with a valid code: latch tx_packet; latch byte_count = min(buffer_occupancy, MAX_PAYLOAD) for data packets; assert tx_transfer_active next cycle.
- tx_start with an invalid code: tx_error pulse next cycle; remain in IDLE.
- tx_start while busy: ignored.
- Bit timing: each bit is held exactly CLKS_PER_BIT cycles; the bit-timer counter wraps 0..CLKS_PER_BIT-1.
- Bit order: all bytes go out LSB first. SYNC byte = 8'h80. PID byte = {~pid[3:0], pid[3:0]}, with pid: DATA0=3, DATA1=B, ACK=2, NAK=A, STALL=E.
- Payload fetch: at the first clock of the last bit time of the PID byte or of the current data byte, pulse get_tx_packet_data if bytes remain.
  - Capture tx_packet_data on the following cycle into a holding register; the buffer output returns to 0 afterwards.
  - Exactly byte_count requests are issued per packet.
- Zero-length data packet (byte_count=0): go from PID directly to CRC_LO; no requests issued.
- CRC16: polynomial 16'h8005 (reflected LSB-first shift), initialised to 16'hFFFF at SYNC.
  - Updated per payload bit only; stuff bits are excluded.
  - Transmitted complemented, low byte first.
- Bit stuffing: a run counter counts consecutive logical 1s from the SYNC first bit through the last CRC bit.
  - After the sixth 1, insert one 0 bit time, reset the counter, and stall the shift and fetch timing by one bit time.
  - A stuff bit due after the final CRC bit is sent before EOP.
- NRZI: logical 0 toggles the line state (J<->K); logical 1 holds it. J = (1,0), K = (0,1). The line state starts at J entering SYNC.
- EOP: SE0 (0,0) for 2 bit times, then J for 1 bit time.
  - tx_done pulses and tx_transfer_active falls on the last clock of EOP_J; state returns to IDLE.
  - NRZI and stuffing do not apply to EOP.
- A new tx_start is accepted on the cycle after tx_done.

Decomposition:
- Package usb_tx_pkg holds:
  - tx_packet code enum.
  - PID constants.
  - SYNC_BYTE, CRC16_POLY, CRC16_INIT.
  - FSM state enum.
- Sub-module usb_crc16: serial CRC16 with clear, shift-enable and bit input, and a 16-bit output.
- The encoder instantiates usb_crc16 and keeps the FSM, bit timer, stuffer and NRZI in the top module.

Test Plan:
- ACK after reset: tx_start, tx_packet=3.
  - Decoded stream is 8'h80, 8'hD2, then SE0 for 8 clk and J for 4 clk.
  - Total 19 bit times = 76 clk; tx_done at clk 76; zero get_tx_packet_data pulses.
- Zero-length DATA1, buffer_occupancy=0: PID byte 8'h4B, CRC bytes 8'h00 8'h00, 35 bit times (140 clk), no fetch requests.
- DATA0 with 1 byte 8'hFF:
  - Exactly one request, issued during PID bit 7.
  - A stuff 0 appears after data bit 3 (run of 2 from the PID plus 4); CRC checked against the reference model.
- DATA0 with 64 bytes of 8'h00 then 8'hFF pattern: 64 requests each one cycle wide; decoded payload and CRC match the model; stuff count matches the model.
- Invalid code: tx_packet=7 gives a tx_error pulse next cycle, lines stay J, and tx_transfer_active stays 0.
- Reset asserted during the DATA state: lines at J immediately, no tx_done; a following ACK transmits correctly.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared packet codes, PIDs, CRC constants and FSM states for the USB
// full-speed transmit encoder.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_DATA0 = 3'd1,
        PKT_DATA1 = 3'd2,
        PKT_ACK   = 3'd3,
        PKT_NAK   = 3'd4,
        PKT_STALL = 3'd5
    } tx_pkt_e;

    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_DATA,
        S_CRC_LO,
        S_CRC_HI,
        S_EOP_SE0,
        S_EOP_J
    } tx_state_e;

    function automatic logic pkt_valid(input logic [2:0] code);
        return (code >= 3'd1) && (code <= 3'd5);
    endfunction

    function automatic logic pkt_is_data(input tx_pkt_e p);
        return (p == PKT_DATA0) || (p == PKT_DATA1);
    endfunction

    // PID byte carries the check nibble (complement) in the upper half.
    function automatic logic [7:0] pid_byte(input tx_pkt_e p);
        logic [3:0] pid;
        case (p)
            PKT_DATA0: pid = PID_DATA0;
            PKT_DATA1: pid = PID_DATA1;
            PKT_ACK:   pid = PID_ACK;
            PKT_NAK:   pid = PID_NAK;
            default:   pid = PID_STALL;
        endcase
        return {~pid, pid};
    endfunction

    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial CRC16, LSB-first (reflected) shift; one payload bit per enabled clock.
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift_en,
    input  logic        din,
    output logic [15:0] crc
);

    localparam logic [15:0] POLY_R = reflect16(CRC16_POLY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            crc <= CRC16_INIT;
        else if (clr)
            crc <= CRC16_INIT;
        else if (shift_en)
            crc <= {1'b0, crc[15:1]} ^ ((crc[0] ^ din) ? POLY_R : 16'h0000);
    end

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed packet serializer: SYNC, PID, payload + CRC16, EOP with
// on-the-fly bit stuffing and NRZI onto D+/D-.
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int MAX_PAYLOAD  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [2:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_transfer_active,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [6:0]       MAX_BYTES = 7'(MAX_PAYLOAD);

    tx_state_e        state, state_d;
    tx_pkt_e          pkt;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       ones_cnt;
    logic             stuff_now;
    logic             prev_k;
    logic             have_next;
    logic             fetch_d;
    logic [6:0]       req_left;
    logic [7:0]       data_hold;
    logic [7:0]       cur_data;
    logic [7:0]       pid_b;
    logic [15:0]      crc;

    logic bit_end, in_bits, cur_bit, line_k, stuff_due, advance;
    logic byte_done, start_ok, load_data, crc_en;

    assign bit_end  = (bit_cnt == CNT_LAST);
    assign in_bits  = state inside {S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI};
    assign pid_b    = pid_byte(pkt);
    assign start_ok = (state == S_IDLE) && tx_start && pkt_valid(tx_packet);

    always_comb begin
        cur_bit = 1'b0;
        if (!stuff_now) begin
            case (state)
                S_SYNC:   cur_bit = SYNC_BYTE[bit_idx];
                S_PID:    cur_bit = pid_b[bit_idx];
                S_DATA:   cur_bit = cur_data[bit_idx];
                S_CRC_LO: cur_bit = ~crc[{1'b0, bit_idx}];
                S_CRC_HI: cur_bit = ~crc[{1'b1, bit_idx}];
                default:  cur_bit = 1'b0;
            endcase
        end
    end

    // prev_k is the line state before this bit; a 0 toggles it.
    assign line_k    = prev_k ^ ~cur_bit;
    assign stuff_due = in_bits && bit_end && !stuff_now && cur_bit && (ones_cnt == 3'd5);
    assign advance   = in_bits && bit_end && !stuff_due;
    assign byte_done = advance && (bit_idx == 3'd7);
    assign crc_en    = (state == S_DATA) && bit_end && !stuff_now;

    // Fetch at the start of the last real bit of PID or of the current data byte.
    assign get_tx_packet_data = ((state == S_PID) || (state == S_DATA)) && (bit_cnt == '0)
                                && (bit_idx == 3'd7) && !stuff_now && (req_left != 7'd0);

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:    if (start_ok) state_d = S_SYNC;
            S_SYNC:    if (byte_done) state_d = S_PID;
            S_PID:     if (byte_done)
                           state_d = !pkt_is_data(pkt) ? S_EOP_SE0 : (have_next ? S_DATA : S_CRC_LO);
            S_DATA:    if (byte_done) state_d = have_next ? S_DATA : S_CRC_LO;
            S_CRC_LO:  if (byte_done) state_d = S_CRC_HI;
            S_CRC_HI:  if (byte_done) state_d = S_EOP_SE0;
            S_EOP_SE0: if (bit_end && (bit_idx == 3'd1)) state_d = S_EOP_J;
            S_EOP_J:   if (bit_end) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign load_data = byte_done && (state_d == S_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt       <= PKT_NONE;
            bit_cnt   <= '0;
            bit_idx   <= 3'd0;
            ones_cnt  <= 3'd0;
            stuff_now <= 1'b0;
            prev_k    <= 1'b0;
            have_next <= 1'b0;
            fetch_d   <= 1'b0;
            req_left  <= 7'd0;
            data_hold <= 8'h00;
            cur_data  <= 8'h00;
            tx_error  <= 1'b0;
        end else begin
            fetch_d  <= get_tx_packet_data;
            tx_error <= (state == S_IDLE) && tx_start && !pkt_valid(tx_packet);

            if (state == S_IDLE) begin
                bit_cnt   <= '0;
                bit_idx   <= 3'd0;
                ones_cnt  <= 3'd0;
                stuff_now <= 1'b0;
                prev_k    <= 1'b0;
                have_next <= 1'b0;
                if (start_ok) begin
                    pkt      <= tx_pkt_e'(tx_packet);
                    req_left <= !pkt_is_data(tx_pkt_e'(tx_packet)) ? 7'd0 :
                                (buffer_occupancy > MAX_BYTES) ? MAX_BYTES : buffer_occupancy;
                end
            end else begin
                bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
                if (advance || ((state == S_EOP_SE0) && bit_end))
                    bit_idx <= bit_idx + 3'd1;
                if (in_bits && bit_end) begin
                    stuff_now <= stuff_due;
                    ones_cnt  <= (cur_bit && !stuff_due) ? ones_cnt + 3'd1 : 3'd0;
                    prev_k    <= line_k;
                end
                if (get_tx_packet_data) begin
                    req_left  <= req_left - 7'd1;
                    have_next <= 1'b1;
                end else if (load_data) begin
                    have_next <= 1'b0;
                end
            end

            if (fetch_d)
                data_hold <= tx_packet_data;
            if (load_data)
                cur_data <= data_hold;
        end
    end

    usb_crc16 u_crc (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == S_SYNC),
        .shift_en (crc_en),
        .din      (cur_bit),
        .crc      (crc)
    );

    always_comb begin
        dplus_out  = 1'b1;
        dminus_out = 1'b0;
        if (in_bits) begin
            dplus_out  = ~line_k;
            dminus_out = line_k;
        end else if (state == S_EOP_SE0) begin
            dplus_out  = 1'b0;
            dminus_out = 1'b0;
        end
    end

    assign tx_transfer_active = (state != S_IDLE);
    assign tx_done            = (state == S_EOP_J) && bit_end;

endmodule
